// File: rtl/pc_pkg.sv
// Shared types and constants for the program-counter sequencer.
package pc_pkg;

  typedef logic [7:0] addr_t;

  localparam addr_t RESET_VEC = 8'h00;

  // Source of the next program-counter value.
  typedef enum logic [2:0] {
    SEQ,
    BR,
    JMP,
    CALL,
    RET
  } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack for pc_sequencer: DEPTH entries, with a depth counter.
// A push while full and a pop while empty are both ignored here. The parent
// flags these cases as errors.
module pc_ras
  import pc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  push_i,
  input  logic  pop_i,
  input  addr_t data_i,
  output addr_t top_o,
  output logic  empty_o,
  output logic  full_o
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] top_idx;
  addr_t            mem_q [DEPTH];

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign top_idx = IDX_W'(cnt_q - CNT_W'(1));
  assign top_o   = empty_o ? RESET_VEC : mem_q[top_idx];

  // Next depth: a pop wins over a push, and overflow/underflow leave the depth unchanged.
  always_comb begin
    // NOTE: assign a default before any branch so that no path leaves cnt_d unassigned, which would infer a latch.
    cnt_d = cnt_q;
    if (pop_i && !empty_o) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else if (push_i && !full_o) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Depth counter register. Reset empties the stack.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Entry storage. A push writes the slot just above the current top.
  always_ff @(posedge clk) begin
    // NOTE: storage is deliberately not reset. The depth counter alone decides which entries are valid.
    if (push_i && !pop_i && !full_o) begin
      mem_q[IDX_W'(cnt_q)] <= data_i;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with relative branch, absolute jump and call/return.
// Build option: define PC_SEQ_RAS_EN to include the return-address stack (pc_ras).
// Without it, call acts as jmp, ret falls through sequentially and flags underflow,
// and the stack status reads empty and never full.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall,
  input  logic       br_taken,
  input  logic [7:0] br_off,
  input  logic       jmp,
  input  logic       call,
  input  logic       ret,
  input  logic [7:0] tgt,
  output logic [7:0] pc_next,
  output logic [7:0] pc_cur,
  output logic       stk_empty,
  output logic       stk_full,
  output logic [1:0] err
);

  if (DEPTH < 2 || DEPTH > 8) begin : g_depth_check
    $error("pc_sequencer: DEPTH must be in 2..8");
  end

  addr_t   pc_q, pc_d;
  addr_t   pc_seq, pc_br;
  addr_t   ras_top;
  logic [1:0] err_q, err_d;
  pc_sel_e sel;

  // Address arithmetic wraps naturally at 8 bits.
  assign pc_seq = pc_q + 8'd1;
  assign pc_br  = pc_q + br_off;

`ifdef PC_SEQ_RAS_EN
  logic ras_push, ras_pop;

  // A simultaneous ret suppresses the push. A ret on an empty stack pops nothing.
  assign ras_push = !stall && call && !ret;
  assign ras_pop  = !stall && ret && !stk_empty;

  pc_ras #(
    .DEPTH (DEPTH)
  ) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push_i  (ras_push),
    .pop_i   (ras_pop),
    .data_i  (pc_seq),
    .top_o   (ras_top),
    .empty_o (stk_empty),
    .full_o  (stk_full)
  );
`else
  assign ras_top   = RESET_VEC;
  assign stk_empty = 1'b1;
  assign stk_full  = 1'b0;
`endif

  // Priority select of the next PC: ret > call > jmp > br_taken > sequential. A stall freezes it.
  always_comb begin
    sel  = SEQ;
    pc_d = pc_seq;
    if (ret) begin
      sel = stk_empty ? SEQ : RET;
    end else if (call) begin
      sel = CALL;
    end else if (jmp) begin
      sel = JMP;
    end else if (br_taken) begin
      sel = BR;
    end

    unique case (sel)
      RET:       pc_d = ras_top;
      CALL, JMP: pc_d = tgt;
      BR:        pc_d = pc_br;
      default:   pc_d = pc_seq;
    endcase

    if (stall) begin
      pc_d = pc_q;
    end
  end

  // Sticky error flags: bit0 is call overflow, bit1 is ret underflow. Both are frozen during a stall.
  assign err_d = err_q | {!stall && ret && stk_empty,
                          !stall && call && !ret && stk_full};

  // PC and error registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= RESET_VEC;
      err_q <= 2'b00;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign pc_next = pc_d;
  assign pc_cur  = pc_q;
  assign err     = err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (DEPTH = 4).
// Expected values follow the build: PC_SEQ_RAS_EN defined or undefined.
module tb_pc_sequencer;

  localparam int DEPTH = 4;
`ifdef PC_SEQ_RAS_EN
  localparam bit RAS_EN = 1'b1;
`else
  localparam bit RAS_EN = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       stall;
  logic       br_taken;
  logic [7:0] br_off;
  logic       jmp;
  logic       call;
  logic       ret;
  logic [7:0] tgt;
  logic [7:0] pc_next;
  logic [7:0] pc_cur;
  logic       stk_empty;
  logic       stk_full;
  logic [1:0] err;

  int checks = 0;
  int errors = 0;

  pc_sequencer #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_off    (br_off),
    .jmp       (jmp),
    .call      (call),
    .ret       (ret),
    .tgt       (tgt),
    .pc_next   (pc_next),
    .pc_cur    (pc_cur),
    .stk_empty (stk_empty),
    .stk_full  (stk_full),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pick the expected value for the build under test.
  function automatic logic [7:0] sel(input logic [7:0] with_ras, input logic [7:0] without_ras);
    return RAS_EN ? with_ras : without_ras;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic idle;
    stall = 0; br_taken = 0; br_off = 8'h00; jmp = 0; call = 0; ret = 0; tgt = 8'h00;
  endtask

  // Advance one rising edge, then sample 1 time unit after it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Short asynchronous reset pulse placed between edges.
  task automatic do_reset;
    @(posedge clk);
    #2;
    rst = 1'b1;
    idle();
    #2;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    idle();

    // Reset state, sampled after the first edge with rst still high.
    #7;
    check("rst_pc", pc_cur, 8'h00);
    check("rst_empty", {7'd0, stk_empty}, 8'h01);
    check("rst_full", {7'd0, stk_full}, 8'h00);
    check("rst_err", {6'd0, err}, 8'h00);
    rst = 1'b0;

    // Free run of 258 cycles, including the wrap from FF to 00.
    for (int i = 0; i < 258; i++) begin
      check("seq_pc", pc_cur, 8'(i));
      check("seq_next", pc_next, 8'(i + 1));
      tick();
    end

    // Negative branch: 10 + F0 gives 00.
    jmp = 1; tgt = 8'h10;
    #1 check("jmp_next", pc_next, 8'h10);
    tick();
    idle();
    check("jmp_pc", pc_cur, 8'h10);
    br_taken = 1; br_off = 8'hF0;
    #1 check("brneg_next", pc_next, 8'h00);
    tick();
    check("brneg_pc", pc_cur, 8'h00);
    idle();
    jmp = 1; tgt = 8'h02;
    tick();
    idle();
    br_taken = 1; br_off = 8'hFC;
    tick();
    check("br_02_fc", pc_cur, 8'hFE);
    br_off = 8'h7F;
    tick();
    check("br_fe_7f", pc_cur, 8'h7D);
    idle();

    // Call/return nesting.
    do_reset();
    check("nest_rst_err", {6'd0, err}, 8'h00);
    jmp = 1; tgt = 8'h05;
    tick();
    idle();
    check("nest_pc05", pc_cur, 8'h05);
    call = 1; tgt = 8'h40;
    tick();
    idle();
    check("nest_call1", pc_cur, 8'h40);
    check("nest_empty1", {7'd0, stk_empty}, sel(8'h00, 8'h01));
    tick();
    check("nest_pc41", pc_cur, 8'h41);
    call = 1; tgt = 8'h80;
    tick();
    idle();
    check("nest_call2", pc_cur, 8'h80);
    ret = 1;
    tick();
    check("nest_ret1", pc_cur, sel(8'h42, 8'h81));
    tick();
    check("nest_ret2", pc_cur, sel(8'h06, 8'h82));
    check("nest_empty", {7'd0, stk_empty}, 8'h01);
    check("nest_err", {6'd0, err}, sel(8'h00, 8'h02));
    idle();

    // Overflow: five calls against a four-entry stack.
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      call = 1; tgt = 8'(k * 16);
      tick();
      check("ovf_call_pc", pc_cur, 8'(k * 16));
      if (k == 4) check("ovf_err_pre", {6'd0, err}, 8'h00);
    end
    check("ovf_err", {6'd0, err}, sel(8'h01, 8'h00));
    check("ovf_full", {7'd0, stk_full}, sel(8'h01, 8'h00));
    idle();
    ret = 1;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("ovf_ret_pc", pc_cur, sel(8'h31 - 8'(16 * j), 8'h51 + 8'(j)));
    end
    check("ovf_empty", {7'd0, stk_empty}, 8'h01);
    check("ovf_err_mid", {6'd0, err}, sel(8'h01, 8'h02));
    tick();
    check("unf_pc", pc_cur, sel(8'h02, 8'h55));
    check("unf_err", {6'd0, err}, sel(8'h03, 8'h02));
    idle();

    // Priority: ret beats call, jmp and br_taken. jmp beats br_taken.
    do_reset();
    call = 1; tgt = 8'h60;
    tick();
    check("pri_call", pc_cur, 8'h60);
    ret = 1; call = 1; jmp = 1; br_taken = 1; tgt = 8'h99; br_off = 8'h05;
    #1 check("pri_all_next", pc_next, sel(8'h01, 8'h61));
    tick();
    check("pri_all_pc", pc_cur, sel(8'h01, 8'h61));
    check("pri_all_empty", {7'd0, stk_empty}, 8'h01);
    check("pri_all_err", {6'd0, err}, sel(8'h00, 8'h02));
    idle();
    jmp = 1; br_taken = 1; tgt = 8'h33; br_off = 8'h10;
    tick();
    check("pri_jmp_br", pc_cur, 8'h33);
    idle();

    // Stall for three cycles with conflicting controls asserted.
    do_reset();
    call = 1; tgt = 8'h70;
    tick();
    check("stl_call", pc_cur, 8'h70);
    stall = 1; call = 1; ret = 1; jmp = 1; tgt = 8'hAA;
    #1 check("stl_next", pc_next, 8'h70);
    for (int s = 0; s < 3; s++) begin
      tick();
      check("stl_pc", pc_cur, 8'h70);
    end
    check("stl_empty", {7'd0, stk_empty}, sel(8'h00, 8'h01));
    check("stl_err", {6'd0, err}, 8'h00);
    idle();
    tick();
    check("stl_release", pc_cur, 8'h71);
    ret = 1;
    tick();
    check("stl_ret", pc_cur, sel(8'h01, 8'h72));
    check("stl_ret_empty", {7'd0, stk_empty}, 8'h01);
    idle();

    // Asynchronous reset between edges, just after a call.
    do_reset();
    ret = 1;
    tick();
    check("ar_unf_pc", pc_cur, 8'h01);
    check("ar_unf_err", {6'd0, err}, 8'h02);
    ret = 0; call = 1; tgt = 8'h20;
    tick();
    check("ar_call_pc", pc_cur, 8'h20);
    check("ar_call_empty", {7'd0, stk_empty}, sel(8'h00, 8'h01));
    #1 rst = 1'b1;
    #1;
    check("ar_pc", pc_cur, 8'h00);
    check("ar_empty", {7'd0, stk_empty}, 8'h01);
    check("ar_full", {7'd0, stk_full}, 8'h00);
    check("ar_err", {6'd0, err}, 8'h00);
    #1 rst = 1'b0;
    idle();
    tick();
    check("ar_first_edge", pc_cur, 8'h01);
    check("ar_first_empty", {7'd0, stk_empty}, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, is the number of return-stack entries; legal values are 2 to 8.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port stall, input, 1 bit: hold all state while high.
REQ-005 Port br_taken, input, 1 bit: take a relative branch this cycle.
REQ-006 Port br_off, input, 8 bits: signed two's-complement branch offset.
REQ-007 Port jmp, input, 1 bit: take an absolute jump to tgt this cycle.
REQ-008 Port call, input, 1 bit: push the return address and jump to tgt.
REQ-009 Port ret, input, 1 bit: pop the return stack and jump to the popped address.
REQ-010 Port tgt, input, 8 bits: absolute target for jmp and call.
REQ-011 Port pc_next, output, 8 bits: combinational next address, which drives the PC register input.
REQ-012 Port pc_cur, output, 8 bits: registered current address.
REQ-013 Port stk_empty, output, 1 bit: high when the return stack holds no entries.
REQ-014 Port stk_full, output, 1 bit: high when the return stack holds DEPTH entries.
REQ-015 Port err, output, 2 bits: sticky error flags; bit0 is overflow, bit1 is underflow.

Function
REQ-016 pc_next SHALL be selected by fixed priority ret > call > jmp > br_taken > sequential.
- ret: pc_next = top of stack.
- call or jmp: pc_next = tgt.
- br_taken: pc_next = pc_cur + br_off.
- sequential: pc_next = pc_cur + 1.
REQ-017 All address arithmetic SHALL be modulo 256.
- 8'hFF + 1 gives 8'h00.
- 8'h02 + 8'hFC gives 8'hFE.
REQ-018 On every rising edge with stall low, pc_cur SHALL load pc_next, giving one-cycle latency from control inputs to pc_cur.
REQ-019 While stall is high, pc_next SHALL equal pc_cur, and the stack and err SHALL hold their values.
REQ-020 A call SHALL push pc_cur + 1 (mod 256) in the same edge that pc_cur loads tgt.
REQ-021 A call while stk_full SHALL still jump to tgt, SHALL discard the push, and SHALL set err[0].
REQ-022 A ret while stk_empty SHALL produce sequential pc_next, SHALL leave the stack unchanged, and SHALL set err[1].
REQ-023 When call and ret are high together, ret SHALL win: the stack pops only, with no push.
REQ-024 err bits SHALL clear only on rst.
REQ-025 stk_empty and stk_full SHALL be registered-state decodes of the stack depth counter.

Reset
REQ-026 Asserting rst SHALL immediately force the following, independent of clk:
- pc_cur = 8'h00
- stack depth = 0, so stk_empty = 1 and stk_full = 0
- err = 2'b00
REQ-027 A rst asserted mid-call or mid-return SHALL discard the in-flight push or pop.
REQ-028 The first rising edge after rst deasserts SHALL behave as a normal cycle.

Configuration
REQ-029 Macro PC_SEQ_RAS_EN SHALL compile the return stack in.
- Defined: behaviour is as REQ-016 to REQ-025.
- Undefined: no stack storage exists; call behaves as jmp; ret behaves as sequential and sets err[1]; stk_empty is tied to 1; stk_full is tied to 0.

Structure
REQ-030 The shared package pc_pkg SHALL hold:
- the 8-bit address typedef
- the reset vector constant 8'h00
- the pc_next source-select enum: SEQ, BR, JMP, CALL, RET
REQ-031 The return stack SHALL be one sub-module, pc_ras.
- Parameter DEPTH.
- Ports: push/pop/data in, top/empty/full out.
- Instantiated only under PC_SEQ_RAS_EN.

Verification
REQ-032 The bench SHALL cover sequential run and wrap-around: release rst, then run 258 free cycles; pc_cur must be 00, 01, ..., FF, 00, 01.
REQ-033 The bench SHALL cover a negative branch: at pc_cur=10 apply br_taken with br_off=F0; next pc_cur must be 00.
REQ-034 The bench SHALL cover call/return nesting: call tgt=40 at pc 05, then call tgt=80 at pc 41, then ret, then ret.
- pc_cur must be 40, 80, 42, 06.
- stk_empty must return to 1.
REQ-035 The bench SHALL cover overflow: with DEPTH=4, issue five calls.
- err[0] must set on the fifth call and pc_cur must equal tgt.
- Four rets must return correctly; a fifth ret must set err[1].
REQ-036 The bench SHALL cover priority and stall:
- ret, call, jmp and br_taken all high in one cycle must select ret.
- With stall high for 3 cycles, pc_cur and stack depth must be unchanged.
REQ-037 The bench SHALL cover asynchronous reset: assert rst between clock edges just after a call.
- pc_cur must go to 00 before the next edge.
- stk_empty must be 1 and err must be 00.
